// File: rtl/slot_alloc_12.sv
// Occupancy tracker for a 12-entry queue: grants the lowest free slot per cycle,
// releases any set of slots via a multi-hot mask, and keeps registered status.
module slot_alloc_12 #(
    parameter logic [11:0] INIT_BUSY = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        alloc_valid,
    output logic        alloc_ready,
    output logic [3:0]  alloc_idx,
    input  logic [11:0] free_mask,
    output logic [11:0] busy,
    output logic [3:0]  free_cnt,
    output logic        full,
    output logic        empty,
    output logic        err_double_free
);

    // Lowest-index priority encoder; returns 0 when nothing is requested.
    function automatic logic [3:0] enc_12(input logic [11:0] req);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 11; i >= 0; i--) begin
            if (req[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [3:0] popcount12(input logic [11:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 12; i++) begin
            cnt = cnt + {3'd0, v[i]};
        end
        return cnt;
    endfunction

    localparam logic [3:0] INIT_FREE = 4'd12 - popcount12(INIT_BUSY);

    logic [11:0] busy_r;
    logic [3:0]  free_cnt_r;
    logic        full_r;
    logic        empty_r;
    logic        err_r;

    logic [11:0] busy_next_s;
    logic        err_next_s;
    logic [11:0] grant_s;
    logic [3:0]  idx_s;
    logic        fire_s;

    assign idx_s       = enc_12(~busy_r);
    assign alloc_idx   = idx_s;
    assign alloc_ready = !full_r && !flush;
    assign fire_s      = alloc_valid && alloc_ready;

    // One-hot grant vector for the slot being allocated this cycle.
    always_comb begin
        grant_s = 12'h000;
        for (int i = 0; i < 12; i++) begin
            if (fire_s && (idx_s == 4'(i))) begin
                grant_s[i] = 1'b1;
            end else begin
                grant_s[i] = 1'b0;
            end
        end
    end

    // Next occupancy and sticky error; the grant comes from a free slot, so
    // clearing before setting never loses an allocation.
    always_comb begin
        busy_next_s = busy_r;
        err_next_s  = err_r;
        if (flush) begin
            busy_next_s = 12'h000;
            err_next_s  = err_r;
        end else begin
            busy_next_s = (busy_r & ~free_mask) | grant_s;
            err_next_s  = err_r | (|(free_mask & ~busy_r));
        end
    end

    // State and status registers, status derived from next-state busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r     <= INIT_BUSY;
            free_cnt_r <= INIT_FREE;
            full_r     <= (INIT_BUSY == 12'hFFF);
            empty_r    <= (INIT_BUSY == 12'h000);
            err_r      <= 1'b0;
        end else begin
            busy_r     <= busy_next_s;
            free_cnt_r <= 4'd12 - popcount12(busy_next_s);
            full_r     <= (busy_next_s == 12'hFFF);
            empty_r    <= (busy_next_s == 12'h000);
            err_r      <= err_next_s;
        end
    end

    assign busy            = busy_r;
    assign free_cnt        = free_cnt_r;
    assign full            = full_r;
    assign empty           = empty_r;
    assign err_double_free = err_r;

endmodule

// File: tb/tb_slot_alloc_12.sv
// Scoreboard bench for slot_alloc_12: a default-reset instance is exercised in
// depth, a second instance with INIT_BUSY=12'h00F checks reset loading.
module tb_slot_alloc_12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        alloc_valid;
    logic [11:0] free_mask;

    logic        ar0, full0, empty0, err0;
    logic [3:0]  idx0, cnt0;
    logic [11:0] busy0;
    logic        ar1, full1, empty1, err1;
    logic [3:0]  idx1, cnt1;
    logic [11:0] busy1;

    typedef struct packed {
        logic [11:0] busy;
        logic [3:0]  cnt;
        logic        full;
        logic        empty;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [11:0] m_busy;
    logic        m_err;
    int          checks = 0;
    int          failures = 0;
    logic [18:0] st0, st1;

    assign st0 = {busy0, cnt0, full0, empty0, err0};
    assign st1 = {busy1, cnt1, full1, empty1, err1};

    slot_alloc_12 u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .alloc_valid(alloc_valid),
        .alloc_ready(ar0), .alloc_idx(idx0), .free_mask(free_mask), .busy(busy0),
        .free_cnt(cnt0), .full(full0), .empty(empty0), .err_double_free(err0)
    );

    slot_alloc_12 #(.INIT_BUSY(12'h00F)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .alloc_valid(alloc_valid),
        .alloc_ready(ar1), .alloc_idx(idx1), .free_mask(free_mask), .busy(busy1),
        .free_cnt(cnt1), .full(full1), .empty(empty1), .err_double_free(err1)
    );

    always #5 clk = ~clk;

    // Reference model of one clock edge for the default instance.
    function automatic exp_t model(input logic [11:0] b, input logic er, input logic f,
                                   input logic av, input logic [11:0] fm);
        exp_t        r;
        logic [11:0] nb;
        logic        ne;
        logic        found;
        logic [11:0] gbit;
        nb = b;
        ne = er;
        gbit = 12'h000;
        found = 1'b0;
        if (f) begin
            nb = 12'h000;
        end else begin
            if (av && (b != 12'hFFF)) begin
                for (int i = 0; i < 12; i++) begin
                    if (!found && !b[i]) begin
                        gbit[i] = 1'b1;
                        found = 1'b1;
                    end
                end
            end
            nb = (b & ~fm) | gbit;
            if ((fm & ~b) != 12'h000) ne = 1'b1;
        end
        r.busy  = nb;
        r.cnt   = 4'(12 - $countones(nb));
        r.full  = (nb == 12'hFFF);
        r.empty = (nb == 12'h000);
        r.err   = ne;
        return r;
    endfunction

    task automatic drive(input logic f, input logic av, input logic [11:0] fm);
        flush = f;
        alloc_valid = av;
        free_mask = fm;
        #1;
    endtask

    task automatic push_and_tick();
        exp_t x;
        x = model(m_busy, m_err, flush, alloc_valid, free_mask);
        sb.push_back(x);
        m_busy = x.busy;
        m_err = x.err;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 12'hFFF);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 12'h000);
        m_busy = 12'h000;
        m_err = 1'b0;
        checks++;
        if (st0 !== {12'h000, 4'd12, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset0 got=%h exp=%h", st0, {12'h000, 4'd12, 1'b0, 1'b1, 1'b0});
        end
        checks++;
        if (st1 !== {12'h00F, 4'd8, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset1 got=%h exp=%h", st1, {12'h00F, 4'd8, 1'b0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b1, 12'h000);
            checks++;
            if (idx0 !== 4'(i) || ar0 !== 1'b1) begin
                failures++;
                $display("FAIL fill_idx got=%0d/%b exp=%0d/1", idx0, ar0, i);
            end
            push_and_tick();
            e = sb.pop_front();
            checks++;
            if (st0 !== e) begin
                failures++;
                $display("FAIL fill_state got=%h exp=%h", st0, e);
            end
        end
        checks++;
        if (st0 !== {12'hFFF, 4'd0, 1'b1, 1'b0, 1'b0} || ar0 !== 1'b0) begin
            failures++;
            $display("FAIL full_state got=%h ready=%b exp=%h ready=0", st0, ar0,
                     {12'hFFF, 4'd0, 1'b1, 1'b0, 1'b0});
        end
        drive(1'b0, 1'b1, 12'h000);
        push_and_tick();
        e = sb.pop_front();
        checks++;
        if (st0 !== e) begin
            failures++;
            $display("FAIL full_hold got=%h exp=%h", st0, e);
        end
    endtask

    task automatic test_free_while_full();
        drive(1'b0, 1'b1, 12'h024);
        checks++;
        if (ar0 !== 1'b0) begin
            failures++;
            $display("FAIL full_ready got=%b exp=0", ar0);
        end
        push_and_tick();
        e = sb.pop_front();
        checks++;
        if (st0 !== e || cnt0 !== 4'd2 || idx0 !== 4'd2) begin
            failures++;
            $display("FAIL free_two got=%h idx=%0d exp=%h idx=2", st0, idx0, e);
        end
        drive(1'b0, 1'b1, 12'h000);
        push_and_tick();
        e = sb.pop_front();
        checks++;
        if (st0 !== e || cnt0 !== 4'd1 || idx0 !== 4'd5) begin
            failures++;
            $display("FAIL refill got=%h idx=%0d exp=%h idx=5", st0, idx0, e);
        end
    endtask

    task automatic test_alloc_free_same();
        drive(1'b1, 1'b0, 12'h000);
        push_and_tick();
        e = sb.pop_front();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 12'h000);
            push_and_tick();
            e = sb.pop_front();
        end
        checks++;
        if (busy0 !== 12'h00F) begin
            failures++;
            $display("FAIL setup_00f got=%h exp=00f", busy0);
        end
        drive(1'b0, 1'b1, 12'h001);
        checks++;
        if (idx0 !== 4'd4) begin
            failures++;
            $display("FAIL same_idx got=%0d exp=4", idx0);
        end
        push_and_tick();
        e = sb.pop_front();
        checks++;
        if (st0 !== e || st0 !== {12'h01E, 4'd8, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL alloc_free got=%h exp=%h", st0, {12'h01E, 4'd8, 3'b000});
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b0, 12'h000);
        push_and_tick();
        e = sb.pop_front();
        for (int i = 0; i < 11; i++) begin
            drive(1'b0, 1'b1, 12'h000);
            push_and_tick();
            e = sb.pop_front();
        end
        checks++;
        if (busy0 !== 12'h7FF) begin
            failures++;
            $display("FAIL setup_7ff got=%h exp=7ff", busy0);
        end
        drive(1'b1, 1'b1, 12'h001);
        checks++;
        if (ar0 !== 1'b0) begin
            failures++;
            $display("FAIL flush_ready got=%b exp=0", ar0);
        end
        push_and_tick();
        e = sb.pop_front();
        checks++;
        if (st0 !== e || st0 !== {12'h000, 4'd12, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL flush_state got=%h exp=%h", st0, {12'h000, 4'd12, 3'b010});
        end
    endtask

    task automatic test_double_free();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 12'h000);
            push_and_tick();
            e = sb.pop_front();
        end
        drive(1'b0, 1'b0, 12'h004);
        push_and_tick();
        e = sb.pop_front();
        checks++;
        if (st0 !== e || busy0 !== 12'h003 || err0 !== 1'b1) begin
            failures++;
            $display("FAIL dbl_free got=%h exp=%h", st0, e);
        end
        for (int i = 0; i < 3; i++) begin
            drive((i == 1), 1'b1, 12'h000);
            push_and_tick();
            e = sb.pop_front();
            checks++;
            if (st0 !== e || err0 !== 1'b1) begin
                failures++;
                $display("FAIL err_sticky got=%h exp=%h", st0, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, 12'h000);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 12'h000);
        m_busy = 12'h000;
        m_err = 1'b0;
        checks++;
        if (st1 !== {12'h00F, 4'd8, 1'b0, 1'b0, 1'b0} || err0 !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got=%h err0=%b exp=%h err0=0", st1, err0,
                     {12'h00F, 4'd8, 3'b000});
        end
        drive(1'b0, 1'b1, 12'h000);
        checks++;
        if (idx1 !== 4'd4 || ar1 !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_idx got=%0d/%b exp=4/1", idx1, ar1);
        end
        push_and_tick();
        e = sb.pop_front();
        checks++;
        if (st0 !== e || busy1 !== 12'h01F || cnt1 !== 4'd7) begin
            failures++;
            $display("FAIL post_reset_alloc got=%h/%h cnt1=%0d exp=%h/01f cnt1=7",
                     st0, busy1, cnt1, e);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        alloc_valid = 1'b0;
        free_mask = 12'h000;
        m_busy = 12'h000;
        m_err = 1'b0;
        test_reset();
        test_fill();
        test_free_while_full();
        test_alloc_free_same();
        test_flush();
        test_double_free();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/slot_alloc_12.md
Name: slot_alloc_12

Overview:
- Tracks occupancy of a 12-entry structure, e.g. issue-queue or load/store-queue slots.
- Grants the lowest-index free slot to one allocation request per cycle.
- Retires any set of slots per cycle via a multi-hot free mask.
- Feeds the inverted busy mask to an internal enc_12 priority encoder and registers the resulting occupancy state; sits between rename/dispatch and the 12-entry queue.

Parameters:
- INIT_BUSY, 12'h000, busy-mask value loaded on reset (1 = slot reserved/occupied).

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- flush  input  1  pipeline flush: clear all slots
- alloc_valid  input  1  dispatch requests one slot this cycle
- alloc_ready  output  1  at least one slot free and no flush this cycle
- alloc_idx  output  4  index of the slot granted when alloc fires (lowest free index)
- free_mask  input  12  multi-hot: slots to release this cycle
- busy  output  12  registered occupancy mask
- free_cnt  output  4  registered number of free slots, 0..12
- full  output  1  registered, busy == 12'hFFF
- empty  output  1  registered, busy == 12'h000
- err_double_free  output  1  sticky: a free targeted a non-busy slot

Behaviour:
- Reset (rst_n low at clock edge):
  - busy <= INIT_BUSY.
  - free_cnt <= 12 - popcount(INIT_BUSY).
  - full and empty derived from INIT_BUSY.
  - err_double_free <= 0.
  - Reset overrides flush, alloc and free in the same cycle.
- alloc_idx: combinational. It is the enc_12 encoding of ~busy, so the lowest free index wins. It reads 0 when full and is meaningless unless alloc_ready = 1.
- alloc_ready: combinational, = !full && !flush. It does not depend on alloc_valid.
- Fire condition: fire = alloc_valid && alloc_ready. On fire, busy[alloc_idx] <= 1 at the next edge, so the grant has 1-cycle latency to the busy output.
- Free: for each i with free_mask[i] = 1, busy[i] <= 0 at the next edge.
  - A freed slot is not visible to allocation until the following cycle. There is no same-cycle free-to-alloc bypass.
- Simultaneous alloc and free: both apply in the same cycle. The alloc index is chosen from the current busy mask, so it never collides with a slot being freed.
- Double free: if free_mask[i] = 1 while busy[i] = 0 and no flush is active, err_double_free <= 1 (sticky until reset). busy[i] stays 0.
- Flush:
  - busy <= 12'h000 (INIT_BUSY is not reapplied).
  - Any alloc and free in the same cycle is ignored, and alloc_ready = 0 that cycle.
  - The error check is suppressed during flush.
- Status outputs: free_cnt, full and empty are registered and computed from next-state busy, so they are always consistent with the busy output in the same cycle.
- Arithmetic: free_cnt next = 12 - popcount(busy_next), in 4-bit unsigned arithmetic. It never exceeds 12 and never wraps.
- Holding alloc_valid high while full causes no state change. The requester must hold its request until alloc_ready is seen.

Test Plan:
- Reset with INIT_BUSY=0, alloc_valid=1 for 12 cycles -> alloc_idx 0,1,…,11 on consecutive cycles. After the 12th edge: busy=FFF, full=1, free_cnt=0, alloc_ready=0.
- From full, free_mask=12'h024 (slots 2 and 5) with alloc_valid=1 -> no alloc that cycle. Next cycle free_cnt=2, alloc_idx=2. After firing, alloc_idx=5 and free_cnt=1.
- busy=12'h00F with same-cycle alloc (idx 4) and free_mask=12'h001 -> next busy=12'h01E, free_cnt=8, err_double_free=0.
- busy=12'h003 with free_mask=12'h004 -> busy unchanged, err_double_free=1 and it stays 1 across later cycles until rst_n=0.
- busy=12'h7FF with flush=1, alloc_valid=1 and free_mask=12'h001 -> alloc_ready=0 that cycle. Next cycle busy=0, empty=1, free_cnt=12, no error.
- INIT_BUSY=12'h00F, hold rst_n=0 for 2 cycles in mid-operation, then alloc -> busy=00F after reset, first alloc_idx=4, free_cnt=8.
